// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the instruction-memory bus, the pipeline control inputs
// and the IF/ID register outputs of the fetch stage.
//   imem_req/imem_addr      fetch -> memory read request and word address
//   imem_ready/imem_rdata   memory -> fetch response (same-cycle allowed)
//   stall                   decode cannot accept a new IF/ID entry
//   redirect_valid/_pc      taken branch/jump and its target word address
//   if_id_*                 IF/ID register contents presented to decode
// master: the fetch unit side. slave: memory/decode environment side.
interface fetch_unit_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready;
   logic [15:0] imem_rdata;
   logic        stall;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        if_id_valid;
   logic [15:0] if_id_instr;
   logic [15:0] if_id_imm;
   logic [15:0] if_id_pc;
   logic [15:0] if_id_pc_next;

   modport master (
      output imem_req, imem_addr,
      input  imem_ready, imem_rdata,
      input  stall, redirect_valid, redirect_pc,
      output if_id_valid, if_id_instr, if_id_imm, if_id_pc, if_id_pc_next
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ready, imem_rdata,
      output stall, redirect_valid, redirect_pc,
      input  if_id_valid, if_id_instr, if_id_imm, if_id_pc, if_id_pc_next
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Reads one word per handshake from
// instruction memory and assembles single- or two-word instructions into the
// IF/ID register. Two-word instructions (opcode 11100, 11101, 11111) buffer the
// first word and emit once the immediate word arrives.
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   fetch_io  fetch_unit_if.master: memory bus, stall/redirect, IF/ID outputs
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master fetch_io
);

   localparam logic [0:0] FETCH1 = 1'b0;
   localparam logic [0:0] FETCH2 = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] buf_instr_q, buf_instr_d;
   logic [15:0] buf_pc_q, buf_pc_d;
   logic        valid_q, valid_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] imm_q, imm_d;
   logic [15:0] id_pc_q, id_pc_d;
   logic [15:0] id_pc_next_q, id_pc_next_d;

   logic        accept;
   logic        req;
   logic        handshake;
   logic        two_word;
   logic [4:0]  opcode;
   logic [15:0] pc_inc;

   assign opcode   = fetch_io.imem_rdata[15:11];
   assign two_word = (opcode == 5'b11100) || (opcode == 5'b11101) || (opcode == 5'b11111);
   // Wraps modulo 2^16, so a two-word instruction at 16'hFFFF reads its immediate from 0.
   assign pc_inc   = pc_q + 16'd1;

   // Accept when the IF/ID slot is empty or being consumed this cycle.
   assign accept    = !valid_q || !fetch_io.stall;
   assign req       = !rst && accept && !fetch_io.redirect_valid;
   assign handshake = req && fetch_io.imem_ready;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      buf_instr_d  = buf_instr_q;
      buf_pc_d     = buf_pc_q;
      valid_d      = valid_q;
      instr_d      = instr_q;
      imm_d        = imm_q;
      id_pc_d      = id_pc_q;
      id_pc_next_d = id_pc_next_q;

      if (fetch_io.redirect_valid) begin
         // Redirect wins over stall and any response arriving this cycle.
         valid_d     = 1'b0;
         pc_d        = fetch_io.redirect_pc;
         state_d     = FETCH1;
         buf_instr_d = 16'h0000;
         buf_pc_d    = 16'h0000;
      end else if (accept) begin
         if (handshake) begin
            pc_d = pc_inc;
            if (state_q == FETCH1) begin
               if (two_word) begin
                  buf_instr_d = fetch_io.imem_rdata;
                  buf_pc_d    = pc_q;
                  state_d     = FETCH2;
                  valid_d     = 1'b0;
               end else begin
                  valid_d      = 1'b1;
                  instr_d      = fetch_io.imem_rdata;
                  imm_d        = 16'h0000;
                  id_pc_d      = pc_q;
                  id_pc_next_d = pc_inc;
               end
            end else begin
               valid_d      = 1'b1;
               instr_d      = buf_instr_q;
               imm_d        = fetch_io.imem_rdata;
               id_pc_d      = buf_pc_q;
               id_pc_next_d = pc_inc;
               state_d      = FETCH1;
            end
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= FETCH1;
         pc_q         <= RESET_PC;
         buf_instr_q  <= 16'h0000;
         buf_pc_q     <= 16'h0000;
         valid_q      <= 1'b0;
         instr_q      <= 16'h0000;
         imm_q        <= 16'h0000;
         id_pc_q      <= 16'h0000;
         id_pc_next_q <= 16'h0000;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         buf_instr_q  <= buf_instr_d;
         buf_pc_q     <= buf_pc_d;
         valid_q      <= valid_d;
         instr_q      <= instr_d;
         imm_q        <= imm_d;
         id_pc_q      <= id_pc_d;
         id_pc_next_q <= id_pc_next_d;
      end
   end

   assign fetch_io.imem_req      = req;
   assign fetch_io.imem_addr     = pc_q;
   assign fetch_io.if_id_valid   = valid_q;
   assign fetch_io.if_id_instr   = instr_q;
   assign fetch_io.if_id_imm     = imm_q;
   assign fetch_io.if_id_pc      = id_pc_q;
   assign fetch_io.if_id_pc_next = id_pc_next_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: imem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port: imem_addr  output  16  word address of the requested instruction word.
REQ-006 SHALL have port: imem_ready  input  1  memory returns imem_rdata this cycle; same-cycle response allowed.
REQ-007 SHALL have port: imem_rdata  input  16  instruction word, valid only when imem_req && imem_ready.
REQ-008 SHALL have port: stall  input  1  decode stage cannot accept a new IF/ID entry.
REQ-009 SHALL have port: redirect_valid  input  1  branch/jump taken; discard in-flight fetch.
REQ-010 SHALL have port: redirect_pc  input  16  target word address for redirect.
REQ-011 SHALL have port: if_id_valid  output  1  IF/ID register holds a complete instruction.
REQ-012 SHALL have port: if_id_instr  output  16  instruction word fed to the control unit; opcode in [15:11].
REQ-013 SHALL have port: if_id_imm  output  16  second word of two-word instructions, else 16'h0000.
REQ-014 SHALL have port: if_id_pc  output  16  address of the instruction's first word.
REQ-015 SHALL have port: if_id_pc_next  output  16  address following the complete instruction.

Function
REQ-016 SHALL classify an instruction as two-word when imem_rdata[15:11] is 5'b11100, 5'b11101 or 5'b11111; all other opcodes are single-word.
REQ-017 SHALL implement states FETCH1 (first word) and FETCH2 (immediate word); reset state FETCH1.
REQ-018 SHALL define accept = !if_id_valid || !stall; imem_req = accept && !redirect_valid in both states; imem_addr = PC.
REQ-019 FETCH1, handshake (req && ready), single-word: load if_id_instr=rdata, if_id_imm=0, if_id_pc=PC, if_id_pc_next=PC+1, if_id_valid=1; PC<=PC+1; stay FETCH1.
REQ-020 FETCH1, handshake, two-word: latch word and PC in internal buffer; PC<=PC+1; go FETCH2; if_id_valid<=0 if the current entry is consumed (!stall), else hold.
REQ-021 FETCH2, handshake: load if_id_instr=buffered word, if_id_imm=rdata, if_id_pc=buffered PC, if_id_pc_next=PC+1, if_id_valid=1; PC<=PC+1; go FETCH1.
REQ-022 No handshake while accept: if_id_valid<=0; PC and state unchanged.
REQ-023 stall && if_id_valid: all if_id_* outputs, PC, state and buffer SHALL hold; no request issued.
REQ-024 redirect_valid SHALL take priority over stall and handshakes: next cycle if_id_valid=0, PC=redirect_pc, state=FETCH1, buffer discarded; rdata in that cycle ignored.
REQ-025 PC arithmetic SHALL be modulo 2^16 (16'hFFFF+1 = 16'h0000), including a two-word instruction straddling the wrap.
REQ-026 Throughput SHALL be one single-word instruction per cycle with imem_ready held high and stall low; two-word instructions take two cycles.
REQ-027 Latency: word returned in cycle N SHALL appear on if_id_* in cycle N+1 (last word for two-word instructions).

Reset
REQ-028 While rst is high: PC=RESET_PC, state=FETCH1, buffer cleared, if_id_valid=0, if_id_instr/imm/pc/pc_next=16'h0000, imem_req=0.
REQ-029 Reset asserted mid two-word fetch SHALL abandon it; first request after release SHALL be to RESET_PC.

Verification
REQ-030 Reset release, ready=1, mem[0..2]=16'h0800,16'h1000,16'h1800 -> if_id_valid=1 three consecutive cycles, if_id_pc 0,1,2, imm=0.
REQ-031 mem[4]=16'hF800, mem[5]=16'h1234 from PC=4 -> one entry: instr=16'hF800, imm=16'h1234, pc=4, pc_next=6; next fetch addr 6.
REQ-032 stall=1 for 3 cycles with valid entry at pc=7 -> outputs unchanged, imem_req=0; after release pc=8 appears one cycle later.
REQ-033 redirect_valid=1, redirect_pc=16'h0040 during FETCH2 -> next cycle if_id_valid=0, imem_addr=16'h0040, partial instruction never issued.
REQ-034 PC=16'hFFFF with two-word opcode 5'b11101 -> entry pc=16'hFFFF, imm from address 0, pc_next=16'h0001.
REQ-035 imem_ready low 2 cycles in FETCH1 -> if_id_valid=0, imem_addr held; issues normally when ready rises.
